// File: rtl/modbus_sram_pkg.sv
// Shared types for the register-space SRAM arbiter:
// FSM states, port owner encoding and the Modbus write mask.
package modbus_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_WB = 1'b0,
    OWN_MB = 1'b1
  } owner_e;

  localparam logic [3:0] MB_WMASK = 4'b0011;

endpackage

// File: rtl/modbus_rr_arb2.sv
// Two-way round-robin picker: bit 0 = Wishbone, bit 1 = Modbus.
// Combinational; the caller only acts on the grant while idle.
module modbus_rr_arb2
  import modbus_sram_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_i,
  output logic [1:0] gnt_o
);

  // a tie goes to whichever side did not own the previous access
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (last_i == OWN_WB) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/modbus_sram_arbiter.sv
// Shares SRAM port 0 between the Wishbone slave and the Modbus
// controller: one access in flight, round-robin, registered controls.
module modbus_sram_arbiter
  import modbus_sram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wbs_cyc,
  input  logic              i_wbs_stb,
  input  logic              i_wbs_we,
  input  logic [3:0]        i_wbs_sel,
  input  logic [31:0]       i_wbs_adr,
  input  logic [31:0]       i_wbs_dat,
  output logic              o_wbs_ack,
  output logic [31:0]       o_wbs_dat,
  input  logic [ADDR_W-1:0] i_mb_addr,
  input  logic              i_mb_wren,
  input  logic              i_mb_rden,
  input  logic [15:0]       i_mb_din,
  output logic [15:0]       o_mb_dout,
  output logic              o_mb_rdvalid,
  output logic              o_mb_wrready,
  output logic              o_mb_drop,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [3:0]        sram_wmask0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [31:0]       sram_din0,
  input  logic [31:0]       sram_dout0
);

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_e state_q, state_d;
  owner_e owner_q, last_q;
  logic              op_we_q;
  logic [1:0]        cnt_q;
  logic [31:0]       rdata_q;

  logic              slot_v_q;
  logic [ADDR_W-1:0] slot_addr_q;
  logic [15:0]       slot_din_q;
  logic              slot_we_q;
  logic              drop_q;

  logic              csb_q, web_q;
  logic [3:0]        wmask_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;

  logic       wb_req, mb_pulse, mb_done;
  logic [1:0] gnt;
  logic       unused_adr;

  assign wb_req   = i_wbs_cyc & i_wbs_stb;
  assign mb_pulse = i_mb_wren | i_mb_rden;
  assign mb_done  = (state_q == ST_DONE) && (owner_q == OWN_MB);

  assign unused_adr = ^{i_wbs_adr[31:ADDR_W+2], i_wbs_adr[1:0]};

  modbus_rr_arb2 u_arb (
    .req_i  ({slot_v_q, wb_req}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (|gnt) state_d = ST_ISSUE;
      ST_ISSUE: state_d = op_we_q ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (cnt_q == 2'd1) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
    endcase
  end

  // completion strobes, one cycle in DONE
  always_comb begin
    o_wbs_ack    = (state_q == ST_DONE) && (owner_q == OWN_WB);
    o_mb_rdvalid = mb_done && !op_we_q;
  end

  // SRAM controls, read capture and grant history
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      owner_q <= OWN_WB;
      last_q  <= OWN_WB;
      op_we_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (gnt[1]) begin
            owner_q <= OWN_MB;
            op_we_q <= slot_we_q;
            csb_q   <= 1'b0;
            web_q   <= ~slot_we_q;
            addr_q  <= slot_addr_q;
            din_q   <= {16'h0, slot_din_q};
            wmask_q <= slot_we_q ? MB_WMASK : 4'b0000;
          end else if (gnt[0]) begin
            owner_q <= OWN_WB;
            op_we_q <= i_wbs_we;
            csb_q   <= 1'b0;
            web_q   <= ~i_wbs_we;
            addr_q  <= i_wbs_adr[ADDR_W+1:2];
            din_q   <= i_wbs_dat;
            wmask_q <= i_wbs_we ? i_wbs_sel : 4'b0000;
          end
        end
        ST_ISSUE: begin
          csb_q <= 1'b1;
          web_q <= 1'b1;
          cnt_q <= LAT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) rdata_q <= sram_dout0;
        end
        ST_DONE: last_q <= owner_q;
      endcase
    end
  end

  // one-deep Modbus request slot and drop flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_v_q    <= 1'b0;
      slot_addr_q <= '0;
      slot_din_q  <= '0;
      slot_we_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= mb_pulse & slot_v_q;
      if (mb_done) begin
        slot_v_q <= 1'b0;
      end else if (mb_pulse && !slot_v_q) begin
        slot_v_q    <= 1'b1;
        slot_addr_q <= i_mb_addr;
        slot_din_q  <= i_mb_din;
        slot_we_q   <= i_mb_wren;
      end
    end
  end

  assign o_wbs_dat    = rdata_q;
  assign o_mb_dout    = rdata_q[15:0];
  assign o_mb_wrready = ~slot_v_q;
  assign o_mb_drop    = drop_q;
  assign sram_csb0    = csb_q;
  assign sram_web0    = web_q;
  assign sram_wmask0  = wmask_q;
  assign sram_addr0   = addr_q;
  assign sram_din0    = din_q;

endmodule

// File: tb/tb_modbus_sram_arbiter.sv
// Directed bench for modbus_sram_arbiter with a 1-cycle
// read SRAM model; expected values are hand-computed.
module tb_modbus_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_wbs_cyc, i_wbs_stb, i_wbs_we;
  logic [3:0]  i_wbs_sel;
  logic [31:0] i_wbs_adr, i_wbs_dat;
  logic        o_wbs_ack;
  logic [31:0] o_wbs_dat;
  logic [7:0]  i_mb_addr;
  logic        i_mb_wren, i_mb_rden;
  logic [15:0] i_mb_din;
  logic [15:0] o_mb_dout;
  logic        o_mb_rdvalid, o_mb_wrready, o_mb_drop;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;

  logic [31:0] mem [256];
  int acc_n = 0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  modbus_sram_arbiter #(.ADDR_W(8), .RD_LAT(1)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wbs_cyc    (i_wbs_cyc),
    .i_wbs_stb    (i_wbs_stb),
    .i_wbs_we     (i_wbs_we),
    .i_wbs_sel    (i_wbs_sel),
    .i_wbs_adr    (i_wbs_adr),
    .i_wbs_dat    (i_wbs_dat),
    .o_wbs_ack    (o_wbs_ack),
    .o_wbs_dat    (o_wbs_dat),
    .i_mb_addr    (i_mb_addr),
    .i_mb_wren    (i_mb_wren),
    .i_mb_rden    (i_mb_rden),
    .i_mb_din     (i_mb_din),
    .o_mb_dout    (o_mb_dout),
    .o_mb_rdvalid (o_mb_rdvalid),
    .o_mb_wrready (o_mb_wrready),
    .o_mb_drop    (o_mb_drop),
    .sram_csb0    (sram_csb0),
    .sram_web0    (sram_web0),
    .sram_wmask0  (sram_wmask0),
    .sram_addr0   (sram_addr0),
    .sram_din0    (sram_din0),
    .sram_dout0   (sram_dout0)
  );

  // SRAM model: byte-masked write, registered 1-cycle read
  always @(posedge clk) begin
    if (!sram_csb0) begin
      acc_n++;
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b])
            mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wb_req(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel);
    i_wbs_cyc = 1'b1;
    i_wbs_stb = 1'b1;
    i_wbs_we  = we;
    i_wbs_adr = adr;
    i_wbs_dat = dat;
    i_wbs_sel = sel;
  endtask

  task automatic wb_off();
    i_wbs_cyc = 1'b0;
    i_wbs_stb = 1'b0;
  endtask

  task automatic wb_wait(output int lat, output logic [31:0] d);
    bit got = 0;
    lat = 0;
    d = '0;
    repeat (20) begin
      @(negedge clk);
      lat++;
      if (o_wbs_ack) begin
        d = o_wbs_dat;
        got = 1;
        break;
      end
    end
    if (!got) lat = 99;
    wb_off();
  endtask

  task automatic mb_wait(output int lat, output logic [15:0] d);
    bit got = 0;
    lat = 0;
    d = '0;
    repeat (20) begin
      @(negedge clk);
      i_mb_rden = 1'b0;
      i_mb_wren = 1'b0;
      lat++;
      if (o_mb_rdvalid) begin
        d = o_mb_dout;
        got = 1;
        break;
      end
    end
    if (!got) lat = 99;
  endtask

  // MB read pulse at cycle 0, WB read raised at cycle 1
  task automatic tie_run(output int rd_c, output int ack_c,
                         output logic [15:0] rdd,
                         output logic [31:0] wbd);
    rd_c = 0;
    ack_c = 0;
    rdd = '0;
    wbd = '0;
    i_mb_addr = 8'h05;
    i_mb_rden = 1'b1;
    @(negedge clk);
    i_mb_rden = 1'b0;
    wb_req(1'b0, 32'h10, 32'h0, 4'h0);
    for (int c = 2; c < 20; c++) begin
      @(negedge clk);
      if (o_mb_rdvalid) begin
        rd_c = c;
        rdd = o_mb_dout;
      end
      if (o_wbs_ack) begin
        ack_c = c;
        wbd = o_wbs_dat;
        wb_off();
      end
      if (rd_c > 0 && ack_c > 0) break;
    end
    wb_off();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, rd_c, ack_c, acc0, rv, ngr, alt_err, cur, prev;
    logic [31:0] d;
    logic [15:0] md;

    rst_n = 1'b0;
    wb_off();
    i_wbs_we = 0; i_wbs_sel = 0;
    i_wbs_adr = 0; i_wbs_dat = 0;
    i_mb_addr = 0; i_mb_din = 0;
    i_mb_wren = 0; i_mb_rden = 0;
    repeat (3) @(negedge clk);

    chk("rst_csb", sram_csb0, 1);
    chk("rst_web", sram_web0, 1);
    chk("rst_wmask", sram_wmask0, 0);
    chk("rst_addr", sram_addr0, 0);
    chk("rst_din", sram_din0, 0);
    chk("rst_ack", o_wbs_ack, 0);
    chk("rst_rdv", o_mb_rdvalid, 0);
    chk("rst_drop", o_mb_drop, 0);
    chk("rst_rdy", o_mb_wrready, 1);
    chk("rst_wbdat", o_wbs_dat, 0);
    chk("rst_mbdout", o_mb_dout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: WB write then read
    wb_req(1'b1, 32'h10, 32'h1234_ABCD, 4'hF);
    @(negedge clk);
    chk("t1_csb", sram_csb0, 0);
    chk("t1_web", sram_web0, 0);
    chk("t1_addr", sram_addr0, 8'h04);
    chk("t1_wmask", sram_wmask0, 4'hF);
    chk("t1_din", sram_din0, 32'h1234_ABCD);
    chk("t1_ack_c1", o_wbs_ack, 0);
    @(negedge clk);
    chk("t1_ack_c2", o_wbs_ack, 1);
    chk("t1_csb_c2", sram_csb0, 1);
    wb_off();
    @(negedge clk);
    chk("t1_ack_c3", o_wbs_ack, 0);
    wb_req(1'b0, 32'h10, 32'h0, 4'h0);
    wb_wait(lat, d);
    chk("t1_rd_lat", lat, 3);
    chk("t1_rd_dat", d, 32'h1234_ABCD);

    // 2: MB write then read
    @(negedge clk);
    chk("t2_rdy_c0", o_mb_wrready, 1);
    i_mb_addr = 8'h05;
    i_mb_din = 16'hBEEF;
    i_mb_wren = 1'b1;
    @(negedge clk);
    i_mb_wren = 1'b0;
    chk("t2_rdy_c1", o_mb_wrready, 0);
    chk("t2_csb_c1", sram_csb0, 1);
    @(negedge clk);
    chk("t2_csb_c2", sram_csb0, 0);
    chk("t2_web", sram_web0, 0);
    chk("t2_wmask", sram_wmask0, 4'b0011);
    chk("t2_addr", sram_addr0, 8'h05);
    chk("t2_din", sram_din0, 32'h0000_BEEF);
    @(negedge clk);
    chk("t2_rdy_done", o_mb_wrready, 0);
    chk("t2_wr_rdv", o_mb_rdvalid, 0);
    @(negedge clk);
    chk("t2_rdy_after", o_mb_wrready, 1);
    i_mb_rden = 1'b1;
    mb_wait(lat, md);
    chk("t2_rd_lat", lat, 4);
    chk("t2_rd_dat", md, 16'hBEEF);
    @(negedge clk);
    chk("t2_rdv_pulse", o_mb_rdvalid, 0);

    // 3: ties after reset, MB first; then alternate
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tie_run(rd_c, ack_c, md, d);
    chk("t3a_mb_cyc", rd_c, 4);
    chk("t3a_wb_cyc", ack_c, 8);
    chk("t3a_mb_dat", md, 16'hBEEF);
    chk("t3a_wb_dat", d, 32'h1234_ABCD);
    @(negedge clk);
    i_mb_addr = 8'h04;
    i_mb_rden = 1'b1;
    mb_wait(lat, md);
    chk("t3_mb_lat", lat, 4);
    chk("t3_mb_dat", md, 16'hABCD);
    @(negedge clk);
    tie_run(rd_c, ack_c, md, d);
    chk("t3b_wb_cyc", ack_c, 4);
    chk("t3b_mb_cyc", rd_c, 8);

    // 4: pulse while slot full is dropped
    @(negedge clk);
    acc0 = acc_n;
    i_mb_addr = 8'h07;
    i_mb_din = 16'h1111;
    i_mb_wren = 1'b1;
    @(negedge clk);
    i_mb_wren = 1'b0;
    chk("t4_full", o_mb_wrready, 0);
    i_mb_addr = 8'h09;
    i_mb_rden = 1'b1;
    @(negedge clk);
    i_mb_rden = 1'b0;
    chk("t4_drop", o_mb_drop, 1);
    @(negedge clk);
    chk("t4_drop_end", o_mb_drop, 0);
    rv = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_mb_rdvalid) rv++;
    end
    chk("t4_rdy", o_mb_wrready, 1);
    chk("t4_no_rdv", rv, 0);
    chk("t4_acc", acc_n - acc0, 1);

    // 5: continuous contention alternates grants
    @(negedge clk);
    wb_req(1'b0, 32'h10, 32'h0, 4'h0);
    i_mb_addr = 8'h05;
    ngr = 0;
    alt_err = 0;
    prev = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!sram_csb0) begin
        cur = (sram_addr0 == 8'h04) ? 0 : 1;
        if (ngr > 0 && cur == prev) alt_err++;
        prev = cur;
        ngr++;
      end
      i_wbs_cyc = !o_wbs_ack;
      i_wbs_stb = !o_wbs_ack;
      i_mb_rden = o_mb_wrready && !i_mb_rden;
    end
    wb_off();
    i_mb_rden = 1'b0;
    chk("t5_alt", alt_err, 0);
    chk("t5_grants", (ngr >= 8) ? 1 : 0, 1);
    repeat (12) @(negedge clk);

    // 6: reset during WAIT
    wb_req(1'b0, 32'h10, 32'h0, 4'h0);
    i_mb_addr = 8'h05;
    i_mb_rden = 1'b1;
    @(negedge clk);
    i_mb_rden = 1'b0;
    chk("t6_csb_issue", sram_csb0, 0);
    chk("t6_full", o_mb_wrready, 0);
    @(negedge clk);
    rst_n = 1'b0;
    wb_off();
    #1;
    chk("t6_csb", sram_csb0, 1);
    chk("t6_web", sram_web0, 1);
    chk("t6_ack", o_wbs_ack, 0);
    chk("t6_rdv", o_mb_rdvalid, 0);
    chk("t6_rdy", o_mb_wrready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wb_req(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF);
    wb_wait(lat, d);
    chk("t6_wr1_lat", lat, 2);
    @(negedge clk);
    wb_req(1'b1, 32'h20, 32'hCAFE_F00D, 4'b0101);
    wb_wait(lat, d);
    chk("t6_wr2_lat", lat, 2);
    @(negedge clk);
    wb_req(1'b0, 32'h20, 32'h0, 4'h0);
    wb_wait(lat, d);
    chk("t6_rd_lat", lat, 3);
    chk("t6_rd_dat", d, 32'hFFFE_FF0D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
